// File: rtl/fmul_pipe.sv
// fmul_pipe: pipelined IEEE-style float multiplier (RNE, denormals flushed to zero).
// Define FMUL_PIPE_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags port.
module fmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 go,
    input  logic                 pipeEn,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 rdy
`ifdef FMUL_PIPE_FLAGS_EN
    ,
    output logic [3:0]           flags
`endif
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam int EMAX = 2**EXP_W - 1;
    localparam int XW   = EXP_W + 2;
    localparam int PW   = 2*MAN_W + 2;

    typedef logic signed [XW-1:0] exp_t;

    localparam exp_t BIAS_X = exp_t'(BIAS);
    localparam exp_t EMAX_X = exp_t'(EMAX);
    localparam exp_t ONE_X  = exp_t'(1);
    localparam exp_t ZERO_X = exp_t'(0);

    // Round-to-nearest-even on a normalised product (hidden bit at the MSB).
    // Returns {carry, hidden, fraction}; carry means the mantissa rolled over to 2.0.
    function automatic logic [MAN_W+1:0] round_rne(input logic [PW-1:0] n);
        logic inc;
        inc = n[MAN_W] & ((|n[MAN_W-1:0]) | n[MAN_W+1]);
        return {1'b0, n[PW-1:MAN_W+1]} + {{(MAN_W+1){1'b0}}, inc};
    endfunction

    // Special values win over the arithmetic result in this priority order.
    function automatic logic [W-1:0] pack(input logic s, input logic nan, input logic inf,
                                          input logic zero, input exp_t e,
                                          input logic [MAN_W-1:0] f);
        logic [W-1:0] r;
        if (nan)
            r = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        else if (inf)
            r = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (zero)
            r = {s, {(W-1){1'b0}}};
        else if (e >= EMAX_X)
            r = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (e <= ZERO_X)
            r = {s, {(W-1){1'b0}}};
        else
            r = {s, e[EXP_W-1:0], f};
        return r;
    endfunction

`ifdef FMUL_PIPE_FLAGS_EN
    function automatic logic [3:0] status(input logic nan, input logic inf, input logic zero,
                                          input exp_t e, input logic inexact);
        logic [3:0] fl;
        if (nan)
            fl = 4'b1000;
        else if (inf || zero)
            fl = 4'b0000;
        else if (e >= EMAX_X)
            fl = 4'b0101;
        else if (e <= ZERO_X)
            fl = 4'b0011;
        else
            fl = {3'b000, inexact};
        return fl;
    endfunction
`endif

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    assign {ea, fa} = a[W-2:0];
    assign {eb, fb} = b[W-2:0];
    assign a_zero   = (ea == '0);
    assign b_zero   = (eb == '0);
    assign a_inf    = (ea == '1) && (fa == '0);
    assign b_inf    = (eb == '1) && (fb == '0);
    assign a_nan    = (ea == '1) && (fa != '0);
    assign b_nan    = (eb == '1) && (fb != '0);

    logic             vld_p0, vld_p1, vld_p2;
    logic             sign_p0, nan_p0, inf_p0, zero_p0;
    logic [MAN_W:0]   ma_p0, mb_p0;
    exp_t             exp_p0;
    logic             sign_p1, nan_p1, inf_p1, zero_p1;
    logic [PW-1:0]    prod_p1;
    exp_t             exp_p1;
    logic [W-1:0]     res_p2;

    logic [PW-1:0]    norm;
    exp_t             exp_n, exp_f;
    logic [MAN_W+1:0] mant_r;
    logic [MAN_W-1:0] frac;

    always_comb begin
        norm   = prod_p1[PW-1] ? prod_p1 : (prod_p1 << 1);
        exp_n  = prod_p1[PW-1] ? (exp_p1 + ONE_X) : exp_p1;
        mant_r = round_rne(norm);
        exp_f  = mant_r[MAN_W+1] ? (exp_n + ONE_X) : exp_n;
        frac   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    end

`ifdef FMUL_PIPE_FLAGS_EN
    logic [3:0] flags_p2;
    logic       inexact;
    assign inexact = norm[MAN_W] | (|norm[MAN_W-1:0]);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            rdy    <= 1'b0;
            result <= '0;
`ifdef FMUL_PIPE_FLAGS_EN
            flags  <= '0;
`endif
        end else if (pipeEn) begin
            vld_p0 <= go;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            rdy    <= vld_p2;
            if (vld_p2) begin
                result <= res_p2;
`ifdef FMUL_PIPE_FLAGS_EN
                flags  <= flags_p2;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pipeEn) begin
            // S1: unpack, classify, biased exponent sum
            sign_p0 <= a[W-1] ^ b[W-1];
            nan_p0  <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
            inf_p0  <= a_inf | b_inf;
            zero_p0 <= a_zero | b_zero;
            ma_p0   <= {1'b1, fa};
            mb_p0   <= {1'b1, fb};
            exp_p0  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;
            // S2: mantissa product
            sign_p1 <= sign_p0;
            nan_p1  <= nan_p0;
            inf_p1  <= inf_p0;
            zero_p1 <= zero_p0;
            prod_p1 <= PW'(ma_p0) * PW'(mb_p0);
            exp_p1  <= exp_p0;
            // S3: normalise, round, pack
            res_p2  <= pack(sign_p1, nan_p1, inf_p1, zero_p1, exp_f, frac);
`ifdef FMUL_PIPE_FLAGS_EN
            flags_p2 <= status(nan_p1, inf_p1, zero_p1, exp_f, inexact);
`endif
        end
    end

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: single- and half-precision fmul_pipe instances checked against an
// exact-integer floating-point model; directed plan vectors plus randomized traffic.
module tb_fmul_pipe;

    logic        clk = 1'b0;
    logic        rst, go, pipeEn;
    logic [31:0] a, b, result;
    logic [15:0] ha, hb, hresult;
    logic        rdy, hrdy;
`ifdef FMUL_PIPE_FLAGS_EN
    logic [3:0]  flags, hflags;
`endif

    always #5 clk = ~clk;

    fmul_pipe dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .go(go), .pipeEn(pipeEn),
        .result(result), .rdy(rdy)
`ifdef FMUL_PIPE_FLAGS_EN
        , .flags(flags)
`endif
    );

    fmul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .a(ha), .b(hb), .go(go), .pipeEn(pipeEn),
        .result(hresult), .rdy(hrdy)
`ifdef FMUL_PIPE_FLAGS_EN
        , .flags(hflags)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Exact product as an integer, rounded to nearest-even by remainder comparison.
    // Returns {invalid, overflow, underflow, inexact, result}.
    function automatic logic [35:0] fmodel(input logic [31:0] x, input logic [31:0] y,
                                           input int ew, input int mw);
        longint one, emax, bias, mmask, ex, ey, fx, fy, p, q, rem, half, e, sgn;
        int k, len;
        logic [31:0] r;
        logic [3:0]  fl;
        one   = 1;
        emax  = (one << ew) - 1;
        bias  = (one << (ew - 1)) - 1;
        mmask = (one << mw) - 1;
        ex    = longint'({32'd0, x} >> mw) & emax;
        ey    = longint'({32'd0, y} >> mw) & emax;
        fx    = longint'({32'd0, x}) & mmask;
        fy    = longint'({32'd0, y}) & mmask;
        sgn   = longint'(x[ew+mw] ^ y[ew+mw]) << (ew + mw);
        fl    = 4'b0000;
        if ((ex == emax && fx != 0) || (ey == emax && fy != 0) ||
            (ex == emax && ey == 0) || (ey == emax && ex == 0)) begin
            fl = 4'b1000;
            r  = 32'((emax << mw) | (one << (mw - 1)));
        end else if (ex == emax || ey == emax) begin
            r = 32'(sgn | (emax << mw));
        end else if (ex == 0 || ey == 0) begin
            r = 32'(sgn);
        end else begin
            p   = (fx | (one << mw)) * (fy | (one << mw));
            len = 0;
            while ((p >> len) != 0) len++;
            k    = len - (mw + 1);
            q    = p >> k;
            rem  = p - (q << k);
            half = one << (k - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            if (q == (one << (mw + 1))) begin
                q = q >> 1;
                k++;
            end
            e = ex + ey - bias - mw + k;
            if (e >= emax) begin
                fl = 4'b0101;
                r  = 32'(sgn | (emax << mw));
            end else if (e <= 0) begin
                fl = 4'b0011;
                r  = 32'(sgn);
            end else begin
                fl = {3'b000, rem != 0};
                r  = 32'(sgn | (e << mw) | (q - (one << mw)));
            end
        end
        return {fl, r};
    endfunction

    function automatic logic [31:0] rnd_op(input int ew, input int mw);
        logic [31:0] s, e, f, emax;
        emax = (32'd1 << ew) - 1;
        s    = 32'($urandom_range(0, 1));
        f    = $urandom & ((32'd1 << mw) - 1);
        case ($urandom_range(0, 8))
            0:       begin e = 0; if ($urandom_range(0, 1) == 1) f = 0; end
            1:       begin e = emax; f = 0; end
            2:       begin e = emax; f = f | 32'd1; end
            3:       e = emax - $urandom_range(1, 3);
            4:       e = $urandom_range(1, 3);
            5:       begin e = $urandom_range(1, emax - 1); f = (32'd1 << mw) - 1; end
            default: e = $urandom_range(1, emax - 1);
        endcase
        return (s << (ew + mw)) | (e << mw) | f;
    endfunction

    typedef struct {
        int          idx;
        logic [35:0] x32;
        logic [35:0] x16;
    } exp_s;

    exp_s sbq[$];
    exp_s mon_e, ce;
    int   ecount  = 0;
    int   cyc_cnt = 0;
    bit   edge_en = 1'b0;

    // Acceptance monitor: model each accepted pair, tagged with its enabled-edge number.
    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt++;
            if (rst) begin
                sbq.delete();
                edge_en = 1'b0;
            end else if (pipeEn) begin
                ecount++;
                edge_en = 1'b1;
                if (go) begin
                    mon_e.idx = ecount;
                    mon_e.x32 = fmodel(a, b, 8, 23);
                    mon_e.x16 = fmodel({16'd0, ha}, {16'd0, hb}, 5, 10);
                    sbq.push_back(mon_e);
                end
            end else begin
                edge_en = 1'b0;
            end
        end
    end

    // Output checker: each result is due exactly 3 enabled edges after acceptance.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_rdy", {hrdy, rdy}, 0);
                chk("rst_result", {hresult, result}, 0);
`ifdef FMUL_PIPE_FLAGS_EN
                chk("rst_flags", {hflags, flags}, 0);
`endif
            end else if (edge_en) begin
                if (sbq.size() > 0 && sbq[0].idx + 3 == ecount) begin
                    ce = sbq.pop_front();
                    chk("rdy", rdy, 1);
                    chk("result", result, ce.x32[31:0]);
                    chk("h_rdy", hrdy, 1);
                    chk("h_result", hresult, ce.x16[15:0]);
`ifdef FMUL_PIPE_FLAGS_EN
                    chk("flags", flags, ce.x32[35:32]);
                    chk("h_flags", hflags, ce.x16[35:32]);
`endif
                end else begin
                    chk("idle_rdy", {hrdy, rdy}, 0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rdy(input int c0, output int lat);
        int n = 0;
        lat = -1;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (rdy) begin
                lat = cyc_cnt - c0;
                break;
            end
        end
    endtask

    logic [31:0] va [10] = '{32'h40000000, 32'h3FC00000, 32'hC0000000, 32'h7F800000, 32'h7F800000,
                             32'h7F7FFFFF, 32'h00800000, 32'h3F800001, 32'h3F800001, 32'h3F800003};
    logic [31:0] vb [10] = '{32'h40400000, 32'h3FC00000, 32'h40400000, 32'h00000000, 32'hC0000000,
                             32'h40000000, 32'h00800000, 32'h3F800001, 32'h3FC00000, 32'h3FC00000};
    logic [31:0] vr [10] = '{32'h40C00000, 32'h40100000, 32'hC0C00000, 32'h7FC00000, 32'hFF800000,
                             32'h7F800000, 32'h00000000, 32'h3F800002, 32'h3FC00002, 32'h3FC00004};
    logic [3:0]  vf [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000,
                             4'b0101, 4'b0011, 4'b0001, 4'b0001, 4'b0001};
    logic [15:0] vha [10] = '{16'h4000, 16'h3E00, 16'hC000, 16'h7C00, 16'h7C00,
                              16'h7BFF, 16'h0400, 16'h3C00, 16'h7E00, 16'h0000};
    logic [15:0] vhb [10] = '{16'h4200, 16'h3E00, 16'h4200, 16'h0000, 16'hC000,
                              16'h4000, 16'h0400, 16'h3C00, 16'h3C00, 16'h8000};
    logic [15:0] vhr [10] = '{16'h4600, 16'h4080, 16'hC600, 16'h7E00, 16'hFC00,
                              16'h7C00, 16'h0000, 16'h3C00, 16'h7E00, 16'h8000};

    logic [35:0] pm;
    int          lat, c0, seen;

    initial begin
        rst = 1'b1; go = 1'b1; pipeEn = 1'b1;
        a = 32'h40000000; b = 32'h40400000; ha = 16'h4000; hb = 16'h4200;
        repeat (3) step();
        rst = 1'b0; go = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            pm = fmodel(va[i], vb[i], 8, 23);
            chk($sformatf("pin_sp%0d", i), pm[31:0], vr[i]);
            chk($sformatf("pin_spflag%0d", i), pm[35:32], vf[i]);
            pm = fmodel({16'd0, vha[i]}, {16'd0, vhb[i]}, 5, 10);
            chk($sformatf("pin_hp%0d", i), pm[15:0], vhr[i]);
        end

        a = 32'h40000000; b = 32'h40400000; ha = 16'h4000; hb = 16'h4200; go = 1'b1;
        step();
        go = 1'b0;
        c0 = cyc_cnt;
        wait_rdy(c0, lat);
        chk("latency", lat, 3);
        chk("first_result", result, 32'h40C00000);
        chk("first_h_result", hresult, 16'h4600);
        step();

        for (int i = 0; i < 10; i++) begin
            a = va[i]; b = vb[i]; ha = vha[i]; hb = vhb[i]; go = 1'b1;
            step();
        end
        go = 1'b0;
        repeat (5) step();

        pipeEn = 1'b0; go = 1'b1;
        repeat (2) step();
        go = 1'b0; pipeEn = 1'b1;
        repeat (5) step();

        a = 32'h40000000; b = 32'h40400000; ha = 16'h4000; hb = 16'h4200; go = 1'b1;
        step();
        go = 1'b0; pipeEn = 1'b0;
        c0 = cyc_cnt;
        repeat (5) step();
        pipeEn = 1'b1;
        wait_rdy(c0, lat);
        chk("stall_latency", lat, 8);
        chk("stall_result", result, 32'h40C00000);
        step();

        go = 1'b1;
        step();
        go = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rdy || hrdy) seen++;
        end
        chk("rst_discard", seen, 0);
        step();

        for (int i = 0; i < 1500; i++) begin
            rst    = (i == 700);
            pipeEn = ($urandom_range(0, 9) < 8);
            go     = ($urandom_range(0, 9) < 7);
            a      = rnd_op(8, 23);
            b      = rnd_op(8, 23);
            ha     = 16'(rnd_op(5, 10));
            hb     = 16'(rnd_op(5, 10));
            step();
        end
        rst = 1'b0; go = 1'b0; pipeEn = 1'b1;
        repeat (6) step();
        chk("drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
- Parametrised, self-contained pipelined floating-point multiplier with no vendor core.
- Drop-in successor to the vendor-wrapped single-precision multiplier in the float operator library. It keeps the go / pipeEn / rdy handshake and the registered-output style of the divider wrapper.
- Adds configurable exponent and mantissa widths, asynchronous reset, special-value handling and round-to-nearest-even.
- Instantiated by generated datapaths wherever a float multiply is scheduled.

Parameters:
- EXP_W, 8, exponent field width. Must be at least 3.
- MAN_W, 23, stored mantissa width, excluding the hidden bit. Must be at least 2.
- Derived, not overridable: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1; EMAX = 2^EXP_W-1.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a  in  W  operand A, IEEE-style packing: sign, exponent, mantissa.
- b  in  W  operand B.
- go  in  1  operand valid; sampled only when pipeEn=1.
- pipeEn  in  1  pipeline enable; 0 freezes every register.
- result  out  W  product; registered and held until the next result.
- rdy  out  1  result valid for the current cycle.

Behaviour:
- Reset: all stage valids = 0, rdy = 0, result = 0. Reset is asynchronous and overrides pipeEn.
  - Reset asserted mid-operation discards every in-flight operand.
  - The first rdy after reset release needs a fresh go.
- Advance rule: every stage register and valid bit loads only when pipeEn=1. With pipeEn=0, all registers, rdy and result hold their values.
- Issue: an operand pair is accepted when go=1 and pipeEn=1. Back-to-back issue on every enabled cycle is allowed (throughput 1 per enabled cycle).
- Latency: rdy=1 and the result appear 3 enabled cycles after acceptance.
  - A go accepted on enabled edge N gives rdy high after enabled edge N+3.
  - Disabled cycles in between add delay but lose no data.
- S1, unpack:
  - sign = sa ^ sb.
  - Field exponent 0 → operand is zero (denormals flush to zero).
  - Exponent EMAX with mantissa 0 → inf; with mantissa ≠ 0 → NaN.
  - Hidden bit is prepended.
  - Biased exponent sum ea+eb-BIAS is kept in a signed width of EXP_W+2 bits.
- S2: unsigned (MAN_W+1)x(MAN_W+1) mantissa product, 2*MAN_W+2 bits wide.
- S3, normalise / round / pack:
  - If the product MSB is set: take the upper bits and exponent+1.
  - Guard = first dropped bit; sticky = OR of the remaining dropped bits.
  - RNE: increment when guard & (sticky | lsb).
  - A rounding carry-out renormalises the mantissa and increments the exponent again.
- Special-value priority, highest first:
  1. Any NaN input, or inf x zero → canonical qNaN: sign 0, exponent all-ones, mantissa MSB 1, rest 0.
  2. inf x nonzero → signed inf.
  3. Zero input → signed zero.
  4. Final exponent ≥ EMAX → signed inf (overflow).
  5. Final exponent ≤ 0 → signed zero (underflow, flush).
- Output register: result loads when S3 is valid and pipeEn=1. rdy loads S3 valid whenever pipeEn=1, so the rdy pulse for each operand is exactly one enabled cycle long.
- Boundary case: if go=1 while pipeEn=0, the operand is ignored, not queued.

Optional Feature:
- Macro: FMUL_PIPE_FLAGS_EN.
- Defined:
  - Adds output port flags [3:0] = {invalid, overflow, underflow, inexact}, registered and updated alongside result.
  - invalid = qNaN produced from inf x zero or from a NaN input.
  - inexact = (guard | sticky) on a finite result, or set by overflow / underflow.
  - Resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults; a=0x40000000 (2.0), b=0x40400000 (3.0), single go → result=0x40C00000, rdy high exactly 3 enabled cycles later for one cycle.
- Back-to-back pairs on consecutive cycles:
  - 1.5x1.5 → 0x40100000.
  - -2.0x3.0 (0xC0000000, 0x40400000) → 0xC0C00000.
  - Expect two consecutive rdy pulses.
- Special values:
  - 0x7F800000 x 0x00000000 → 0x7FC00000 (flags invalid=1 with the macro).
  - 0x7F800000 x 0xC0000000 → 0xFF800000.
- Range limits:
  - 0x7F7FFFFF x 0x40000000 → 0x7F800000 (overflow).
  - 0x00800000 x 0x00800000 → 0x00000000 (underflow).
- Stall and reset: issue 2.0x3.0, hold pipeEn=0 for 5 cycles after the first edge → rdy delayed by 5 cycles with result still 0x40C00000. Repeat with rst pulsed mid-flight → no rdy.
- Parameters EXP_W=5, MAN_W=10 (half precision); 0x4000 x 0x4200 (2.0x3.0) → 0x4600 after 3 enabled cycles.
